// File: rtl/io_serial_port_if.sv
// CPU I/O bus as seen by a peripheral: strobes, port select, write data and zero-latency read data.
interface io_serial_port_if;
   logic       rd;
   logic       wr;
   logic [1:0] rs;
   logic [7:0] wdata;
   logic [7:0] rdata;

   modport master (output rd, wr, rs, wdata, input rdata);
   modport slave  (input rd, wr, rs, wdata, output rdata);
endinterface

// File: rtl/io_serial_port.sv
// Four-port I/O responder: 8N1 transmitter behind a small FIFO, single-byte 8N1 receiver
// with overrun/framing flags, and an 8-bit GPIO output/input pair.
module io_serial_port #(
   parameter int unsigned DIV        = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   io_serial_port_if.slave bus,
   output logic            txd,
   input  logic            rxd,
   output logic [7:0]      gpio_out,
   input  logic [7:0]      gpio_in
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = 8;

   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Port decode
   logic wr_tx_c, wr_ctl_c, wr_gpio_c, rd_rx_c;

   assign wr_tx_c   = bus.wr && (bus.rs == 2'd0);
   assign wr_ctl_c  = bus.wr && (bus.rs == 2'd1);
   assign wr_gpio_c = bus.wr && (bus.rs == 2'd2);
   assign rd_rx_c   = bus.rd && (bus.rs == 2'd0);

   // TX FIFO; the extra pointer bit distinguishes full from empty
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wptr, wptr_d;
   logic [PW-1:0] rptr, rptr_d;
   logic          fifo_empty_c, fifo_full_c, push_c, pop_c;
   logic [7:0]    fifo_head_c;

   assign fifo_empty_c = (wptr == rptr);
   assign fifo_full_c  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign fifo_head_c  = fifo_mem[rptr[AW-1:0]];
   assign push_c       = wr_tx_c && (!fifo_full_c || pop_c);
   assign wptr_d       = push_c ? wptr + PW'(1) : wptr;
   assign rptr_d       = pop_c  ? rptr + PW'(1) : rptr;

   always_ff @(posedge clk) begin
      if (push_c) fifo_mem[wptr[AW-1:0]] <= bus.wdata;
   end

   // Transmitter
   logic [1:0]    tx_state, tx_state_d;
   logic [CW-1:0] tx_baud, tx_baud_d;
   logic [2:0]    tx_bit, tx_bit_d;
   logic [7:0]    tx_shift, tx_shift_d;
   logic          txd_d;
   logic          tx_idle_c;

   assign tx_idle_c = fifo_empty_c && (tx_state == ST_IDLE);

   always_comb begin
      tx_state_d = tx_state;
      tx_baud_d  = tx_baud;
      tx_bit_d   = tx_bit;
      tx_shift_d = tx_shift;
      txd_d      = txd;
      pop_c      = 1'b0;
      case (tx_state)
         ST_IDLE: begin
            if (!fifo_empty_c) begin
               pop_c      = 1'b1;
               tx_shift_d = fifo_head_c;
               tx_baud_d  = '0;
               txd_d      = 1'b0;
               tx_state_d = ST_START;
            end
         end
         ST_START: begin
            if (tx_baud == BAUD_LAST) begin
               tx_baud_d  = '0;
               tx_bit_d   = '0;
               txd_d      = tx_shift[0];
               tx_shift_d = {1'b0, tx_shift[7:1]};
               tx_state_d = ST_DATA;
            end else begin
               tx_baud_d = tx_baud + CW'(1);
            end
         end
         ST_DATA: begin
            if (tx_baud == BAUD_LAST) begin
               tx_baud_d = '0;
               if (tx_bit == 3'd7) begin
                  txd_d      = 1'b1;
                  tx_state_d = ST_STOP;
               end else begin
                  tx_bit_d   = tx_bit + 3'd1;
                  txd_d      = tx_shift[0];
                  tx_shift_d = {1'b0, tx_shift[7:1]};
               end
            end else begin
               tx_baud_d = tx_baud + CW'(1);
            end
         end
         ST_STOP: begin
            // A queued byte starts immediately so back-to-back frames have no idle gap
            if (tx_baud == BAUD_LAST) begin
               tx_baud_d = '0;
               if (!fifo_empty_c) begin
                  pop_c      = 1'b1;
                  tx_shift_d = fifo_head_c;
                  txd_d      = 1'b0;
                  tx_state_d = ST_START;
               end else begin
                  tx_state_d = ST_IDLE;
               end
            end else begin
               tx_baud_d = tx_baud + CW'(1);
            end
         end
         default: tx_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= ST_IDLE;
         tx_baud  <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         txd      <= 1'b1;
         wptr     <= '0;
         rptr     <= '0;
      end else begin
         tx_state <= tx_state_d;
         tx_baud  <= tx_baud_d;
         tx_bit   <= tx_bit_d;
         tx_shift <= tx_shift_d;
         txd      <= txd_d;
         wptr     <= wptr_d;
         rptr     <= rptr_d;
      end
   end

   // Receiver; rxd_q holds the previous synchronised sample for falling-edge detection
   logic          rxd_m, rxd_s, rxd_q;
   logic [1:0]    rx_state, rx_state_d;
   logic [CW-1:0] rx_baud, rx_baud_d;
   logic [2:0]    rx_bit, rx_bit_d;
   logic [7:0]    rx_shift, rx_shift_d;
   logic [7:0]    rx_data, rx_data_d;
   logic          rx_valid, rx_valid_d;
   logic          ovr, ovr_d;
   logic          ferr, ferr_d;
   logic          rx_done_c;

   always_comb begin
      rx_state_d = rx_state;
      rx_baud_d  = rx_baud;
      rx_bit_d   = rx_bit;
      rx_shift_d = rx_shift;
      rx_done_c  = 1'b0;
      case (rx_state)
         ST_IDLE: begin
            if (rxd_q && !rxd_s) begin
               rx_baud_d  = '0;
               rx_state_d = ST_START;
            end
         end
         ST_START: begin
            // Mid-bit recheck rejects short low glitches
            if (rx_baud == HALF_LAST) begin
               rx_baud_d  = '0;
               rx_bit_d   = '0;
               rx_state_d = rxd_s ? ST_IDLE : ST_DATA;
            end else begin
               rx_baud_d = rx_baud + CW'(1);
            end
         end
         ST_DATA: begin
            if (rx_baud == BAUD_LAST) begin
               rx_baud_d  = '0;
               rx_shift_d = {rxd_s, rx_shift[7:1]};
               if (rx_bit == 3'd7) rx_state_d = ST_STOP;
               else                rx_bit_d   = rx_bit + 3'd1;
            end else begin
               rx_baud_d = rx_baud + CW'(1);
            end
         end
         ST_STOP: begin
            if (rx_baud == BAUD_LAST) begin
               rx_baud_d  = '0;
               rx_done_c  = 1'b1;
               rx_state_d = ST_IDLE;
            end else begin
               rx_baud_d = rx_baud + CW'(1);
            end
         end
         default: rx_state_d = ST_IDLE;
      endcase
   end

   // Flag updates: clears first, so a same-edge set always wins; a same-edge read frees the buffer
   always_comb begin
      rx_data_d  = rx_data;
      rx_valid_d = rx_valid && !rd_rx_c;
      ovr_d      = ovr  && !(wr_ctl_c && bus.wdata[3]);
      ferr_d     = ferr && !(wr_ctl_c && bus.wdata[4]);
      if (rx_done_c) begin
         if (!rxd_s) begin
            ferr_d = 1'b1;
         end else if (!rx_valid || rd_rx_c) begin
            rx_data_d  = rx_shift;
            rx_valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_m    <= 1'b1;
         rxd_s    <= 1'b1;
         rxd_q    <= 1'b1;
         rx_state <= ST_IDLE;
         rx_baud  <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         ovr      <= 1'b0;
         ferr     <= 1'b0;
      end else begin
         rxd_m    <= rxd;
         rxd_s    <= rxd_m;
         rxd_q    <= rxd_s;
         rx_state <= rx_state_d;
         rx_baud  <= rx_baud_d;
         rx_bit   <= rx_bit_d;
         rx_shift <= rx_shift_d;
         rx_data  <= rx_data_d;
         rx_valid <= rx_valid_d;
         ovr      <= ovr_d;
         ferr     <= ferr_d;
      end
   end

   // GPIO
   logic [7:0] gpio_m, gpio_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         gpio_m   <= '0;
         gpio_s   <= '0;
         gpio_out <= '0;
      end else begin
         gpio_m   <= gpio_in;
         gpio_s   <= gpio_m;
         if (wr_gpio_c) gpio_out <= bus.wdata;
      end
   end

   // Read mux, zero when not reading
   always_comb begin
      bus.rdata = '0;
      if (bus.rd) begin
         case (bus.rs)
            2'd0:    bus.rdata = rx_data;
            2'd1:    bus.rdata = {3'b000, ferr, ovr, rx_valid, tx_idle_c, fifo_full_c};
            2'd2:    bus.rdata = gpio_out;
            default: bus.rdata = gpio_s;
         endcase
      end
   end
endmodule

// File: tb/tb_io_serial_port.sv
// Randomised bench for io_serial_port against a frame-timeline TX model and a byte-level RX model.
module tb_io_serial_port;
   localparam int unsigned DIV    = 4;
   localparam int unsigned DEPTH  = 4;
   localparam int          FRAME  = 10 * DIV;
   // edges from the first start-bit cycle to the edge that completes the byte
   localparam int          L_DONE = 3 + DIV / 2 + 9 * DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic       txd;
   logic [7:0] gpio_out;
   logic [7:0] gpio_in = 8'h00;

   io_serial_port_if bus();

   io_serial_port #(.DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .txd      (txd),
      .rxd      (rxd),
      .gpio_out (gpio_out),
      .gpio_in  (gpio_in)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // TX model: queue of waiting bytes plus the start edge of the frame on the wire
   int         e_cnt   = 0;
   logic [7:0] txq[$];
   bit         tx_act  = 1'b0;
   int         tx_fs   = 0;
   logic [7:0] tx_cur  = 8'h00;
   logic       exp_txd = 1'b1;
   bit         tx_chk_en = 1'b0;
   bit         endf, popf, pushf;
   int         bpos;

   always @(posedge clk) begin
      if (rst) begin
         txq.delete();
         tx_act  = 1'b0;
         exp_txd = 1'b1;
      end else begin
         endf  = tx_act && ((e_cnt - tx_fs) == FRAME);
         popf  = (!tx_act || endf) && (txq.size() > 0);
         pushf = bus.wr && (bus.rs == 2'd0) && ((txq.size() < DEPTH) || popf);
         if (popf) begin
            tx_cur = txq.pop_front();
            tx_fs  = e_cnt;
            tx_act = 1'b1;
         end else if (endf) begin
            tx_act = 1'b0;
         end
         if (pushf) txq.push_back(bus.wdata);
         if (tx_act) begin
            bpos = (e_cnt - tx_fs) / DIV;
            if (bpos == 0)      exp_txd = 1'b0;
            else if (bpos == 9) exp_txd = 1'b1;
            else                exp_txd = tx_cur[bpos-1];
         end else begin
            exp_txd = 1'b1;
         end
      end
      e_cnt++;
   end

   always @(negedge clk) begin
      if (tx_chk_en) check_eq("txd", 32'(txd), 32'(exp_txd));
   end

   // RX / GPIO model
   logic [7:0] m_data  = 8'h00;
   bit         m_valid = 1'b0;
   bit         m_ovr   = 1'b0;
   bit         m_ferr  = 1'b0;
   logic [7:0] g_exp   = 8'h00;

   function automatic logic [7:0] exp_status();
      logic idle_b, full_b;
      idle_b = !tx_act && (txq.size() == 0);
      full_b = (txq.size() == DEPTH);
      return {3'b000, m_ferr, m_ovr, m_valid, idle_b, full_b};
   endfunction

   task automatic bus_cycle(input logic r, input logic w, input logic [1:0] s,
                            input logic [7:0] d, output logic [7:0] q);
      @(negedge clk);
      bus.rd = r; bus.wr = w; bus.rs = s; bus.wdata = d;
      #1 q = bus.rdata;
   endtask

   task automatic idle(input int n);
      logic [7:0] q;
      repeat (n) bus_cycle(1'b0, 1'b0, 2'd0, 8'h00, q);
   endtask

   task automatic wr_reg(input logic [1:0] s, input logic [7:0] d);
      logic [7:0] q;
      bus_cycle(1'b0, 1'b1, s, d, q);
      if (s == 2'd1) begin
         if (d[3]) m_ovr  = 1'b0;
         if (d[4]) m_ferr = 1'b0;
      end
      if (s == 2'd2) g_exp = d;
   endtask

   task automatic rd_reg(input logic [1:0] s, output logic [7:0] q);
      bus_cycle(1'b1, 1'b0, s, 8'h00, q);
   endtask

   task automatic chk_status(input string tag);
      logic [7:0] q;
      rd_reg(2'd1, q);
      check_eq(tag, 32'(q), 32'(exp_status()));
   endtask

   task automatic chk_rx_read(input string tag);
      logic [7:0] q;
      rd_reg(2'd0, q);
      check_eq(tag, 32'(q), 32'(m_data));
      m_valid = 1'b0;
   endtask

   task automatic wait_tx_idle(input int maxc);
      int n = 0;
      while ((tx_act || txq.size() != 0) && n < maxc) begin
         idle(1);
         n++;
      end
      check_eq("tx_drain_bound", 32'(n < maxc), 32'd1);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rxd = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (DIV) @(negedge clk);
         rxd = b[i];
      end
      repeat (DIV) @(negedge clk);
      rxd = stop;
      repeat (DIV) @(negedge clk);
      rxd = 1'b1;
   endtask

   // act: 0 nothing, 1 port-0 read on the completion edge, 2 flag-clear write on that edge
   task automatic rx_frame(input logic [7:0] b, input logic stop, input int act);
      logic [7:0] q;
      logic [7:0] pre;
      pre = m_data;
      fork
         send_frame(b, stop);
         begin
            repeat (L_DONE - 1) @(negedge clk);
            if (act == 1)      bus_cycle(1'b1, 1'b0, 2'd0, 8'h00, q);
            else if (act == 2) bus_cycle(1'b0, 1'b1, 2'd1, 8'h18, q);
            else               bus_cycle(1'b0, 1'b0, 2'd0, 8'h00, q);
            idle(1);
         end
      join
      if (act == 1) check_eq("rx_edge_read", 32'(q), 32'(pre));
      if (act == 2) begin
         m_ovr  = 1'b0;
         m_ferr = 1'b0;
      end
      if (!stop) begin
         m_ferr = 1'b1;
         if (act == 1) m_valid = 1'b0;
      end else if (!m_valid || act == 1) begin
         m_data  = b;
         m_valid = 1'b1;
      end else begin
         m_ovr = 1'b1;
      end
      idle(2);
   endtask

   initial begin
      logic [7:0] q;
      logic [7:0] v;
      bus.rd = 1'b0; bus.wr = 1'b0; bus.rs = 2'd0; bus.wdata = 8'h00;

      // Reset
      idle(2);
      rst = 1'b0;
      tx_chk_en = 1'b1;
      rd_reg(2'd1, q);
      check_eq("reset_status", 32'(q), 32'h02);
      check_eq("reset_gpio_out", 32'(gpio_out), 32'h00);
      check_eq("reset_txd", 32'(txd), 32'd1);

      // Single frame
      wr_reg(2'd0, 8'hA5);
      idle(1);
      check_eq("a5_busy_status", 32'(exp_status()), 32'h00);
      chk_status("a5_busy");
      wait_tx_idle(FRAME + 10);
      chk_status("a5_idle");

      // FIFO fill and overflow drop
      for (int i = 1; i <= 6; i++) wr_reg(2'd0, 8'(i));
      rd_reg(2'd1, q);
      check_eq("fifo_full_bit", 32'(q[0]), 32'd1);
      check_eq("fifo_full_status", 32'(q), 32'(exp_status()));
      wait_tx_idle(6 * FRAME + 20);
      chk_status("fifo_drained");

      // Random TX traffic
      for (int i = 0; i < 20; i++) begin
         wr_reg(2'd0, 8'($urandom));
         idle($urandom_range(0, 30));
         if ($urandom_range(0, 2) == 0) chk_status("tx_rand_status");
      end
      wait_tx_idle(6 * FRAME + 20);

      // RX, overrun, clear
      rx_frame(8'h3C, 1'b1, 0);
      chk_status("rx_3c_status");
      chk_rx_read("rx_3c_read");
      rx_frame(8'h3C, 1'b1, 0);
      rx_frame(8'h77, 1'b1, 0);
      chk_status("rx_ovr_status");
      chk_rx_read("rx_ovr_data");
      wr_reg(2'd1, 8'h08);
      chk_status("rx_ovr_clear");

      // Glitch, framing error, same-edge events
      @(negedge clk); rxd = 1'b0;
      @(negedge clk); rxd = 1'b1;
      idle(3 * DIV);
      chk_status("rx_glitch");
      rx_frame(8'h11, 1'b1, 0);
      rx_frame(8'h55, 1'b0, 0);
      chk_status("rx_ferr");
      rx_frame(8'h22, 1'b1, 1);
      chk_status("rx_edge_read_status");
      chk_rx_read("rx_edge_read_data");
      rx_frame(8'h33, 1'b0, 2);
      chk_status("rx_set_beats_clear");
      wr_reg(2'd1, 8'h18);

      // Random RX
      for (int i = 0; i < 14; i++) begin
         rx_frame(8'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 2));
         chk_status("rx_rand_status");
         if ($urandom_range(0, 1) == 0) chk_rx_read("rx_rand_read");
         if ($urandom_range(0, 3) == 0) wr_reg(2'd1, 8'($urandom));
      end

      // GPIO
      wr_reg(2'd2, 8'hC3);
      idle(1);
      check_eq("gpio_out_c3", 32'(gpio_out), 32'(g_exp));
      rd_reg(2'd2, q);
      check_eq("gpio_rb_c3", 32'(q), 32'hC3);
      bus_cycle(1'b0, 1'b1, 2'd2, 8'h00, q);
      check_eq("rdata_idle_zero", 32'(q), 32'h00);
      wr_reg(2'd2, 8'hC3);
      bus_cycle(1'b1, 1'b1, 2'd2, 8'h3C, q);
      g_exp = 8'h3C;
      check_eq("gpio_rdwr_old", 32'(q), 32'hC3);
      idle(1);
      check_eq("gpio_rdwr_new", 32'(gpio_out), 32'(g_exp));
      for (int i = 0; i < 8; i++) begin
         v = 8'($urandom);
         wr_reg(2'd2, v);
         rd_reg(2'd2, q);
         check_eq("gpio_rand_rb", 32'(q), 32'(v));
      end
      idle(3);
      v = 8'h00;
      idle(1);
      gpio_in = 8'h5A;
      rd_reg(2'd3, q);
      check_eq("gpio_in_one_cycle", 32'(q), 32'(v));
      rd_reg(2'd3, q);
      check_eq("gpio_in_two_cycles", 32'(q), 32'h5A);
      for (int i = 0; i < 6; i++) begin
         v = 8'($urandom);
         idle(1);
         gpio_in = v;
         idle(1);
         rd_reg(2'd3, q);
         check_eq("gpio_in_rand", 32'(q), 32'(v));
      end

      // Reset in the middle of a frame with bytes still queued
      rx_frame(8'h9E, 1'b1, 0);
      wr_reg(2'd0, 8'h00);
      wr_reg(2'd0, 8'hF0);
      wr_reg(2'd0, 8'h0F);
      idle(15);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; g_exp = 8'h00;
      check_eq("rst_mid_txd", 32'(txd), 32'd1);
      check_eq("rst_mid_gpio", 32'(gpio_out), 32'h00);
      rd_reg(2'd1, q);
      check_eq("rst_mid_status", 32'(q), 32'h02);
      rd_reg(2'd0, q);
      check_eq("rst_mid_rxdata", 32'(q), 32'h00);
      idle(2 * FRAME);
      chk_status("rst_mid_quiet");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
